nexys_starship_spawn_scheduler: RTL and testbench
=================================================

# nexys_starship_spawn_scheduler

Turns the per-lane random strobes from the starship PRNG into alien spawn events for the top, bottom, left and right lanes. It sits between the PRNG and the game-logic/VGA blocks. It does three things:
- round-robin arbitration among requesting lanes;
- a cap on the number of simultaneously active aliens;
- a minimum spacing between spawns.

Game logic reports when an alien is destroyed or escapes, which frees its lane.

## Interface
Parameters:
- COOLDOWN, 25: cycles spent in COOL after each spawn. Legal range 1..2^CD_W-1.
- CD_W, 26: width of the cooldown timer.
- MAX_ACTIVE, 2: maximum number of lanes occupied at once. Legal range 1..4.

Ports:
- Clk  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  game running; level-sensitive.
- req  in  4  PRNG strobes. Bit 0 top, 1 btm, 2 left, 3 right.
- clear  in  4  lane alien gone; one-hot or multi-hot, same bit order as req.
- spawn_pulse  out  4  one-hot, one-cycle spawn command.
- spawn_dir  out  2  index of the last spawned lane; held until the next spawn.
- active  out  4  lane-occupied flags.
- active_count  out  3  popcount of active.
- spawn_total  out  8  spawn counter; wraps 255->0.
- busy  out  1  high while in COOL.

## Operation
- State machine states: IDLE, ARB, COOL. Round-robin pointer ptr is 2 bits.
- IDLE:
  - active, timer and spawn_pulse are held at 0.
  - Enable=1 moves to ARB on the next edge.
- Enable=0 in any state:
  - next edge goes to IDLE;
  - active clears to 0;
  - timer clears to 0;
  - spawn_total, ptr and spawn_dir keep their values.
- clear handling, in every state:
  - clear[i] sets active[i] to 0 at the next edge;
  - clear on an inactive lane is ignored.
- ARB:
  - eligible = req & ~active & ~clear.
  - cnt = popcount(active & ~clear).
  - If eligible≠0 and cnt<MAX_ACTIVE, grant the first eligible lane scanning ptr, ptr+1, ... mod 4.
- On a grant, at the next edge:
  - spawn_pulse[g]=1;
  - active[g]=1;
  - spawn_dir=g;
  - ptr=g+1 mod 4;
  - spawn_total+1;
  - timer=COOLDOWN-1;
  - state goes to COOL.
- ARB with no grant: stay in ARB. No request is stored; the PRNG strobe must be present in an ARB cycle to count.
- COOL:
  - req is ignored;
  - timer decrements each cycle;
  - at timer==0, next state is ARB.
- A clear that lands in the same cycle as a grant to a different lane applies normally.
- active_count is combinational from the registered active.
- Reset values:
  - state IDLE, ptr 0, timer 0;
  - spawn_pulse 0, spawn_dir 0, active 0, spawn_total 0, busy 0.
  - Reset asserted mid-COOL aborts immediately to these values.

## Timing
- Latency: a req sampled in ARB at edge t gives spawn_pulse high for exactly cycle t+1. The outputs are registered.
- busy is high for the COOLDOWN cycles t+1 .. t+COOLDOWN.
- ARB resumes at t+COOLDOWN+1.
- Minimum spacing between spawn_pulse rising edges is COOLDOWN+1 cycles.
- A clear sampled at edge t drops active at t+1. That lane is eligible again in the next ARB cycle.
- spawn_total wrap: 255 + 1 = 0. No saturation and no flag.
- Enable falling during COOL: IDLE on the next edge. The pending cooldown is discarded.
- Enable rising: first possible spawn_pulse is 2 cycles later (IDLE→ARB, then grant).

## Test plan
- Reset, Enable=1, req=4'b0001 held, COOLDOWN=25 → spawn_pulse=0001 once.
  - active=0001, spawn_dir=0, busy high 25 cycles.
  - No second spawn, because lane 0 stays active.
- req=4'b1111 held, MAX_ACTIVE=4, clear pulsed after each spawn → grants in order top, btm, left, right, top.
  - Pulses exactly 26 cycles apart.
  - spawn_total increments by 1 per grant.
- MAX_ACTIVE=2, req=1111 → two spawns (lanes 0 and 1), then none.
  - clear=0001 → next ARB grants lane 2, because ptr=2.
  - active_count goes 2→1→2.
- ARB cycle with req=0010 and clear=0010 on active lane 1 → no grant that cycle.
  - active[1]=0 at the next edge.
  - Grant to lane 1 on the following ARB cycle if req is still high.
- Enable dropped mid-COOL (timer=10) → IDLE, active=0, busy=0.
  - spawn_total unchanged.
  - Enable=1 with req=0100 → spawn_pulse=0100 two cycles later.
- 256 spawns with clear returned each time → spawn_total reads 0.
  - Async Reset mid-COOL → all outputs 0 before the next Clk edge.

Source files
------------

// File: rtl/nexys_starship_spawn_scheduler.sv
// ---------------------------------------------------------------------------
// nexys_starship_spawn_scheduler
//
// Converts per-lane PRNG strobes into alien spawn commands. Requesting lanes
// are served round-robin. The number of occupied lanes is capped, and every
// spawn is followed by a fixed cooldown. Game logic frees a lane through
// `clear` when its alien is destroyed or escapes.
//
// Ports
//   Clk           in   1  clock
//   Reset         in   1  asynchronous, active-high reset
//   Enable        in   1  game running (level); low forces IDLE
//   req           in   4  PRNG strobes: bit0 top, bit1 btm, bit2 left, bit3 right
//   clear         in   4  lane alien gone (multi-hot, same order as req)
//   spawn_pulse   out  4  one-hot, one-cycle spawn command
//   spawn_dir     out  2  index of the last spawned lane (held)
//   active        out  4  lane-occupied flags
//   active_count  out  3  popcount of active (combinational from registered active)
//   spawn_total   out  8  spawn counter, wraps 255->0
//   busy          out  1  high while cooling down
// ---------------------------------------------------------------------------
module nexys_starship_spawn_scheduler #(
    parameter int unsigned COOLDOWN   = 25,
    parameter int unsigned CD_W       = 26,
    parameter int unsigned MAX_ACTIVE = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [3:0] req,
    input  logic [3:0] clear,
    output logic [3:0] spawn_pulse,
    output logic [1:0] spawn_dir,
    output logic [3:0] active,
    output logic [2:0] active_count,
    output logic [7:0] spawn_total,
    output logic       busy
);

    localparam int unsigned LANES = 4;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN - 1);
    localparam logic [2:0]      MAX_A   = 3'(MAX_ACTIVE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        COOL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [3:0]        r_active;
    logic [CD_W-1:0]   r_timer;
    logic [3:0]        r_pulse;
    logic [1:0]        r_dir;
    logic [1:0]        r_ptr;
    logic [7:0]        r_total;
    logic              r_busy;

    logic [3:0]        w_active_nxt;
    logic [CD_W-1:0]   w_timer_nxt;
    logic [3:0]        w_pulse_nxt;
    logic [1:0]        w_dir_nxt;
    logic [1:0]        w_ptr_nxt;
    logic [7:0]        w_total_nxt;
    logic              w_busy_nxt;

    logic [3:0]        w_elig;
    logic [2:0]        w_cnt;
    logic [1:0]        w_idx;
    logic [1:0]        w_gnt;
    logic              w_found;
    logic              w_grant;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Round-robin scan starting at r_ptr. A lane being cleared this cycle is
    // neither eligible nor counted against the cap.
    always_comb begin
        w_elig  = req & ~r_active & ~clear;
        w_cnt   = popcnt4(r_active & ~clear);
        w_idx   = 2'd0;
        w_gnt   = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < int'(LANES); k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
        w_grant = w_found && (w_cnt < MAX_A);
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active & ~clear;
        w_timer_nxt  = r_timer;
        w_pulse_nxt  = 4'b0000;
        w_dir_nxt    = r_dir;
        w_ptr_nxt    = r_ptr;
        w_total_nxt  = r_total;
        w_busy_nxt   = 1'b0;

        if (!Enable) begin
            // Leaving play discards occupancy and any pending cooldown.
            w_state_nxt  = IDLE;
            w_active_nxt = 4'b0000;
            w_timer_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_active_nxt = 4'b0000;
                    w_timer_nxt  = '0;
                    w_state_nxt  = ARB;
                end
                ARB: begin
                    if (w_grant) begin
                        w_pulse_nxt  = 4'b0001 << w_gnt;
                        w_active_nxt = (r_active & ~clear) | (4'b0001 << w_gnt);
                        w_dir_nxt    = w_gnt;
                        w_ptr_nxt    = w_gnt + 2'd1;
                        w_total_nxt  = r_total + 8'd1;
                        w_timer_nxt  = CD_LOAD;
                        w_state_nxt  = COOL;
                    end
                end
                COOL: begin
                    if (r_timer == '0) begin
                        w_state_nxt = ARB;
                    end else begin
                        w_timer_nxt = r_timer - CD_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == COOL);
    end

    // Datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_active <= 4'b0000;
            r_timer  <= '0;
            r_pulse  <= 4'b0000;
            r_dir    <= 2'd0;
            r_ptr    <= 2'd0;
            r_total  <= 8'd0;
            r_busy   <= 1'b0;
        end else begin
            r_active <= w_active_nxt;
            r_timer  <= w_timer_nxt;
            r_pulse  <= w_pulse_nxt;
            r_dir    <= w_dir_nxt;
            r_ptr    <= w_ptr_nxt;
            r_total  <= w_total_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign spawn_pulse  = r_pulse;
    assign spawn_dir    = r_dir;
    assign active       = r_active;
    assign active_count = popcnt4(r_active);
    assign spawn_total  = r_total;
    assign busy         = r_busy;

endmodule

// File: tb/tb_nexys_starship_spawn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_nexys_starship_spawn_scheduler
//
// Directed bench for the spawn scheduler. Two instances share all inputs:
// u_d2 uses MAX_ACTIVE=2, u_d4 uses MAX_ACTIVE=4; both use COOLDOWN=25.
// Inputs change 1 time unit after a rising edge, outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_nexys_starship_spawn_scheduler;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Enable;
    logic [3:0] req;
    logic [3:0] clear;

    logic [3:0] p2, p4;
    logic [1:0] d2, d4;
    logic [3:0] a2, a4;
    logic [2:0] c2, c4;
    logic [7:0] t2, t4;
    logic       b2, b4;

    int n_chk = 0;
    int n_err = 0;

    nexys_starship_spawn_scheduler #(.COOLDOWN(25), .CD_W(26), .MAX_ACTIVE(2)) u_d2 (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .req(req), .clear(clear),
        .spawn_pulse(p2), .spawn_dir(d2), .active(a2), .active_count(c2),
        .spawn_total(t2), .busy(b2)
    );

    nexys_starship_spawn_scheduler #(.COOLDOWN(25), .CD_W(26), .MAX_ACTIVE(4)) u_d4 (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .req(req), .clear(clear),
        .spawn_pulse(p4), .spawn_dir(d4), .active(a4), .active_count(c4),
        .spawn_total(t4), .busy(b4)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        Enable = 1'b0;
        req    = 4'b0000;
        clear  = 4'b0000;
        step();
        step();
        Reset  = 1'b0;
    endtask

    // Steps until the chosen instance pulses; n = cycles taken, -1 on timeout.
    task automatic wait_pulse(input bit use4, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if ((use4 ? p4 : p2) != 4'b0000) begin
                n = i;
                break;
            end
        end
    endtask

    int n, nb, np, ok;
    logic [3:0] exp_lane [5];

    initial begin
        exp_lane[0] = 4'b0001;
        exp_lane[1] = 4'b0010;
        exp_lane[2] = 4'b0100;
        exp_lane[3] = 4'b1000;
        exp_lane[4] = 4'b0001;

        // ---- reset state ----
        do_reset();
        chk("rst_pulse", 32'(p2), 32'h0);
        chk("rst_dir",   32'(d2), 32'h0);
        chk("rst_active",32'(a2), 32'h0);
        chk("rst_count", 32'(c2), 32'h0);
        chk("rst_total", 32'(t2), 32'h0);
        chk("rst_busy",  32'(b2), 32'h0);

        // ---- single lane, cooldown length, no respawn on occupied lane ----
        Enable = 1'b1;
        req    = 4'b0001;
        wait_pulse(1'b0, 10, n);
        chk("t1_latency", 32'(n), 32'd2);
        chk("t1_pulse",   32'(p2), 32'h1);
        chk("t1_active",  32'(a2), 32'h1);
        chk("t1_dir",     32'(d2), 32'h0);
        chk("t1_total",   32'(t2), 32'h1);
        chk("t1_count",   32'(c2), 32'h1);
        nb = 1;
        np = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (p2 != 4'b0000) np++;
            if (b2) nb++;
            else break;
        end
        chk("t1_busy_len", 32'(nb), 32'd25);
        for (int i = 0; i < 60; i++) begin
            step();
            if (p2 != 4'b0000) np++;
        end
        chk("t1_no_respawn", 32'(np), 32'd0);
        chk("t1_total_hold", 32'(t2), 32'h1);

        // ---- MAX_ACTIVE=4 round robin with clear after each spawn ----
        do_reset();
        Enable = 1'b1;
        req    = 4'b1111;
        wait_pulse(1'b1, 10, n);
        chk("t2_first_lat", 32'(n), 32'd2);
        for (int g = 0; g < 5; g++) begin
            if (g != 0) begin
                wait_pulse(1'b1, 60, n);
                chk($sformatf("t2_gap%0d", g), 32'(n + 1), 32'd26);
            end
            chk($sformatf("t2_lane%0d", g),  32'(p4), 32'(exp_lane[g]));
            chk($sformatf("t2_total%0d", g), 32'(t4), 32'(g + 1));
            clear = p4;
            step();
            clear = 4'b0000;
        end

        // ---- MAX_ACTIVE=2 cap, then release lets ptr continue at lane 2 ----
        do_reset();
        Enable = 1'b1;
        req    = 4'b1111;
        wait_pulse(1'b0, 10, n);
        chk("t3_p0", 32'(p2), 32'h1);
        wait_pulse(1'b0, 60, n);
        chk("t3_gap",  32'(n), 32'd26);
        chk("t3_p1",   32'(p2), 32'h2);
        chk("t3_act",  32'(a2), 32'h3);
        chk("t3_cnt2", 32'(c2), 32'd2);
        np = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (p2 != 4'b0000) np++;
        end
        chk("t3_capped", 32'(np), 32'd0);
        req   = 4'b0000;
        clear = 4'b0001;
        step();
        chk("t3_cnt1",  32'(c2), 32'd1);
        chk("t3_act1",  32'(a2), 32'h2);
        clear = 4'b0000;
        req   = 4'b1111;
        step();
        chk("t3_p2",    32'(p2), 32'h4);
        chk("t3_act2",  32'(a2), 32'h6);
        chk("t3_cnt2b", 32'(c2), 32'd2);
        chk("t3_dir",   32'(d2), 32'd2);

        // ---- clear and request on the same lane in one ARB cycle ----
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!b2) begin
                ok = 1;
                break;
            end
        end
        chk("t4_cool_end", 32'(ok), 32'd1);
        req   = 4'b0010;
        clear = 4'b0010;
        step();
        chk("t4_nogrant", 32'(p2), 32'h0);
        chk("t4_act",     32'(a2), 32'h4);
        clear = 4'b0000;
        step();
        chk("t4_grant",   32'(p2), 32'h2);
        chk("t4_act2",    32'(a2), 32'h6);
        chk("t4_dir",     32'(d2), 32'd1);

        // ---- Enable dropped mid-cooldown (timer=10) ----
        for (int i = 0; i < 14; i++) step();
        chk("t5_busy_pre", 32'(b2), 32'd1);
        Enable = 1'b0;
        step();
        chk("t5_busy",   32'(b2), 32'd0);
        chk("t5_active", 32'(a2), 32'h0);
        chk("t5_pulse",  32'(p2), 32'h0);
        chk("t5_total",  32'(t2), 32'd4);
        chk("t5_dir",    32'(d2), 32'd1);
        req    = 4'b0100;
        Enable = 1'b1;
        wait_pulse(1'b0, 10, n);
        chk("t5_latency", 32'(n), 32'd2);
        chk("t5_pulse2",  32'(p2), 32'h4);
        chk("t5_total2",  32'(t2), 32'd5);

        // ---- 256 spawns wrap the counter, then async reset mid-cooldown ----
        do_reset();
        Enable = 1'b1;
        req    = 4'b0001;
        ok = 0;
        for (int i = 0; i < 256; i++) begin
            wait_pulse(1'b0, 60, n);
            if (n > 0) ok++;
            clear = 4'b0001;
            step();
            clear = 4'b0000;
        end
        chk("t6_spawns", 32'(ok), 32'd256);
        chk("t6_wrap",   32'(t2), 32'd0);
        wait_pulse(1'b0, 60, n);
        chk("t6_after_wrap", 32'(t2), 32'd1);
        step();
        step();
        step();
        chk("t6_busy_pre", 32'(b2), 32'd1);
        Reset = 1'b1;
        #2;
        chk("t6_ar_busy",   32'(b2), 32'd0);
        chk("t6_ar_active", 32'(a2), 32'h0);
        chk("t6_ar_count",  32'(c2), 32'd0);
        chk("t6_ar_pulse",  32'(p2), 32'h0);
        chk("t6_ar_total",  32'(t2), 32'd0);
        chk("t6_ar_dir",    32'(d2), 32'd0);
        Reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
